// File: rtl/fifo_reader.sv
// Burst reader: pops len words from a source FIFO into a 2-entry skid buffer, 2-cycle pop-to-valid, 1 word/cycle.
// Pops stall on downstream backpressure or FIFO empty; define FIFO_READER_CNT_EN to add the word_cnt output.
module fifo_reader #(
    parameter int DW = 8,
    parameter int LW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [LW-1:0] len,
    input  logic          fifo_empty,
    input  logic [DW-1:0] fifo_data,
    output logic          fifo_pop,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done
`ifdef FIFO_READER_CNT_EN
    ,
    output logic [LW-1:0] word_cnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] rem_q, rem_d;
    logic          infl_q, infl_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] buf_q [2];

    logic          leave;
    logic          pop;
    logic [2:0]    occ;

    always_comb begin
        leave    = (cnt_q != 2'd0) && out_ready;
        // Occupancy after this cycle's departure; a pop now lands in the buffer two edges later.
        occ      = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, leave};
        pop      = (state_q == S_RUN) && !fifo_empty && (rem_q != '0) && (occ < 3'd2);

        state_d  = state_q;
        rem_d    = rem_q;
        infl_d   = pop;
        cnt_d    = cnt_q + {1'b0, infl_q} - {1'b0, leave};
        wr_ptr_d = infl_q ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d = leave ? ~rd_ptr_q : rd_ptr_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        rem_d   = len;
                        state_d = S_RUN;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (pop) begin
                    rem_d = rem_q - LW'(1);
                    if (rem_q == LW'(1)) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Leave as the last word departs so done follows the final transfer directly.
                if (!infl_q && cnt_d == 2'd0) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rem_q    <= '0;
            infl_q   <= 1'b0;
            cnt_q    <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            infl_q   <= infl_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (infl_q) buf_q[wr_ptr_q] <= fifo_data;
    end

    // Outputs are forced quiet for the whole reset cycle, not only after the edge.
    assign fifo_pop  = pop && !rst;
    assign out_valid = (cnt_q != 2'd0) && !rst;
    assign out_data  = rst ? '0 : buf_q[rd_ptr_q];
    assign busy      = (state_q != S_IDLE) && !rst;
    assign done      = (state_q == S_DONE) && !rst;

`ifdef FIFO_READER_CNT_EN
    logic [LW-1:0] wcnt_q, wcnt_d;

    always_comb begin
        wcnt_d = wcnt_q;
        if (state_q == S_IDLE && start) wcnt_d = '0;
        else if (leave)                 wcnt_d = wcnt_q + LW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) wcnt_q <= '0;
        else     wcnt_q <= wcnt_d;
    end

    assign word_cnt = wcnt_q;
`endif

endmodule
